// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between the EX-stage issue (req0) and the branch unit (req1).
// Define ALU_ARB_FIXED_PRIO_EN to make req0 always win ties instead of alternating.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [7:0]  req_op,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        gnt;
    logic        last_grant;
    logic        sel;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_legal;
    logic        take;

    always_comb begin
        sel = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        sel = ~req_valid[0];
`else
        if (&req_valid)
            sel = ~last_grant;
        else
            sel = req_valid[1];
`endif
    end

    assign sel_op    = sel ? req_op[7:4]  : req_op[3:0];
    assign sel_a     = sel ? req_a[63:32] : req_a[31:0];
    assign sel_b     = sel ? req_b[63:32] : req_b[31:0];
    // The supported codes are exactly 0000..0111
    assign sel_legal = ~sel_op[3];

    assign take      = (state == IDLE) && (|req_valid) && !rst;
    assign req_ready = take ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (state == RESP) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_ctrl   <= 4'd0;
            rsp_data   <= 32'd0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    gnt <= sel;
                    if (sel_legal) begin
                        alu_a    <= sel_a;
                        alu_b    <= sel_b;
                        alu_ctrl <= sel_op;
                        cnt      <= 4'd0;
                        state    <= EXEC;
                    end else begin
                        // Illegal op skips the ALU; operand regs keep their last values
                        rsp_data <= 32'd0;
                        rsp_zero <= 1'b0;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end
                end
                EXEC: begin
                    if (cnt == CNT_LAST) begin
                        rsp_data <= alu_result;
                        rsp_zero <= alu_zero;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: if (rsp_ready[gnt]) begin
                    last_grant <= gnt;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: randomized and directed requests checked against a transaction-level model.
module tb_alu_arbiter;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [7:0]  req_op = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;

    alu_arbiter #(.ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0011: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b0100: return a << b[4:0];
            4'b0111: return 32'($signed(a) >>> b[4:0]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0101, 4'b0100, 4'b0111};
    endfunction

    // Behavioural ALU sitting on the far side of the arbiter
    assign alu_result = ref_alu(alu_ctrl, alu_a, alu_b);
    assign alu_zero   = (alu_result == 32'd0);

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        zero;
        logic        err;
        int          due;
    } ent_t;

    ent_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        last_g = 1'b1;
    logic [1:0]  acc = '0;
    logic [31:0] exp_a = '0, exp_b = '0;
    logic [3:0]  exp_ctrl = '0;
    logic [3:0]  tmpl_op [2];
    logic [31:0] tmpl_a [2];
    logic [31:0] tmpl_b [2];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Accept side: predicts the grant, checks req_ready and ALU operands, pushes the expected response
    always @(negedge clk) begin
        logic [1:0] er;
        logic       gi;
        logic [3:0] op;
        logic [31:0] a, b, r;
        er = '0;
        gi = 1'b0;
        if (rst) begin
            acc = '0;
        end else begin
            if (q.size() == 0 && req_valid != 2'b00) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                gi = req_valid[0] ? 1'b0 : 1'b1;
`else
                gi = (req_valid == 2'b11) ? ~last_g : req_valid[1];
`endif
                er[gi] = 1'b1;
            end
            chk(req_ready == er, "req_ready", 64'(req_ready), 64'(er));
            chk(alu_a == exp_a, "alu_a", 64'(alu_a), 64'(exp_a));
            chk(alu_b == exp_b, "alu_b", 64'(alu_b), 64'(exp_b));
            chk(alu_ctrl == exp_ctrl, "alu_ctrl", 64'(alu_ctrl), 64'(exp_ctrl));
            acc = er & req_valid;
            if (acc != 2'b00) begin
                op = req_op[4*gi +: 4];
                a  = req_a[32*gi +: 32];
                b  = req_b[32*gi +: 32];
                if (is_legal(op)) begin
                    r = ref_alu(op, a, b);
                    q.push_back('{id: gi, data: r, zero: (r == 0), err: 1'b0, due: cyc + LAT + 1});
                    exp_a = a; exp_b = b; exp_ctrl = op;
                end else begin
                    q.push_back('{id: gi, data: 32'd0, zero: 1'b0, err: 1'b1, due: cyc + 1});
                end
            end
        end
    end

    // Response monitor: pops and compares whenever the head response is due
    always @(negedge clk) begin
        logic [1:0] ev;
        #1;
        ev = '0;
        if (!rst) begin
            if (q.size() > 0 && cyc >= q[0].due) ev[q[0].id] = 1'b1;
            chk(rsp_valid == ev, "rsp_valid", 64'(rsp_valid), 64'(ev));
            if (ev != 2'b00) begin
                chk(rsp_data == q[0].data, "rsp_data", 64'(rsp_data), 64'(q[0].data));
                chk(rsp_zero == q[0].zero, "rsp_zero", 64'(rsp_zero), 64'(q[0].zero));
                chk(rsp_err == q[0].err, "rsp_err", 64'(rsp_err), 64'(q[0].err));
                if (rsp_ready[q[0].id]) begin
                    last_g = q[0].id;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    // en: requesters allowed to issue; rnd: random ops/readies; rr: rsp_ready when not random
    task automatic run(input int n, input logic [1:0] en, input bit rnd, input logic [1:0] rr);
        logic [3:0] op;
        logic [31:0] a, b;
        for (int k = 0; k < n; k++) begin
            cyc1();
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if (en[i] && (!rnd || $urandom_range(0, 2) != 0)) begin
                        if (rnd) begin
                            op = ($urandom_range(0, 4) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
                            a  = $urandom;
                            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
                        end else begin
                            op = tmpl_op[i]; a = tmpl_a[i]; b = tmpl_b[i];
                        end
                        req_valid[i]     = 1'b1;
                        req_op[4*i +: 4] = op;
                        req_a[32*i +: 32] = a;
                        req_b[32*i +: 32] = b;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if (rnd && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = rnd ? 2'($urandom) : rr;
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((q.size() != 0 || req_valid != 2'b00) && b < 300) begin
            run(1, 2'b00, 1'b0, 2'b11);
            b++;
        end
        chk(b < 300, "drain_timeout", 64'(b), 64'd300);
    endtask

    task automatic set_tmpl(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        tmpl_op[i] = op; tmpl_a[i] = a; tmpl_b[i] = b;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(req_ready == 2'b00, {tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk(rsp_valid == 2'b00, {tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({rsp_data, rsp_zero, rsp_err} == 34'd0, {tag, "_rsp"}, 64'({rsp_data, rsp_zero, rsp_err}), 64'd0);
        chk({alu_a, alu_b, alu_ctrl} == 68'd0, {tag, "_alu"}, 64'({alu_a, alu_ctrl}), 64'd0);
    endtask

    initial begin
        int b;
        repeat (3) cyc1();
        req_valid = 2'b11;
        #1;
        chk_reset_outputs("reset");
        req_valid = 2'b00;
        rst = 1'b0;

        // Single ADD on req0, then SUB to zero on req1
        set_tmpl(0, 4'b0010, 32'd5, 32'd7);
        run(1, 2'b01, 1'b0, 2'b11);
        drain();
        set_tmpl(1, 4'b0110, 32'h10, 32'h10);
        run(1, 2'b10, 1'b0, 2'b11);
        drain();

        // Contention with continuous requests from both sides
        set_tmpl(0, 4'b0000, 32'hF0, 32'h3C);
        set_tmpl(1, 4'b0001, 32'hF0, 32'h0F);
        run(5 * (LAT + 2), 2'b11, 1'b0, 2'b11);
        drain();

        // Illegal op must leave the ALU operands alone
        set_tmpl(0, 4'b1000, 32'h1234, 32'h5678);
        run(1, 2'b01, 1'b0, 2'b11);
        drain();

        // Backpressure on req0, with req1's stray rsp_ready that must be ignored
        set_tmpl(0, 4'b0011, 32'hA5A5_0000, 32'h0000_5A5A);
        set_tmpl(1, 4'b0010, 32'd1, 32'd1);
        run(1, 2'b01, 1'b0, 2'b10);
        run(LAT + 5, 2'b10, 1'b0, 2'b10);
        drain();

        // Reset in the middle of EXEC, then a tie that must go to req0
        set_tmpl(0, 4'b0010, 32'd100, 32'd200);
        set_tmpl(1, 4'b0100, 32'd1, 32'd4);
        b = 0;
        do begin
            run(1, 2'b11, 1'b0, 2'b11);
            b++;
        end while (acc == 2'b00 && b < 50);
        chk(b < 50, "accept_timeout", 64'(b), 64'd50);
        rst = 1'b1;
        cyc1();
        chk_reset_outputs("midop");
        q.delete();
        last_g = 1'b1;
        exp_a = '0; exp_b = '0; exp_ctrl = '0;
        req_valid = 2'b11;
        rst = 1'b0;
        run(3 * (LAT + 2), 2'b11, 1'b0, 2'b11);
        drain();

        // Randomized traffic
        run(2000, 2'b11, 1'b1, 2'b11);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit integer ALU between two requesters: req0 is the EX-stage issue and req1 is the branch/address-compare unit.
- Accepts an operation per requester over valid/ready, grants round-robin, and holds ALU operands stable for ALU_LAT cycles.
- Captures result and zero flag, then returns them to the granted requester over valid/ready.
- Sits between the pipeline control and the ALU instance.

Parameters:
ALU_LAT, 1, cycles ALU operands are held before result capture (legal 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  2  per-requester operation valid (bit0=req0, bit1=req1)
req_ready  output  2  per-requester accept; at most one bit high per cycle
req_a  input  64  operand A, {req1_a, req0_a}
req_b  input  64  operand B, {req1_b, req0_b}
req_op  input  8  ALU control code, {req1_op, req0_op}
rsp_valid  output  2  per-requester response valid
rsp_ready  input  2  per-requester response accept
rsp_data  output  32  result for the granted requester
rsp_zero  output  1  zero flag for the granted requester
rsp_err  output  1  high when the granted op code was unsupported
alu_a  output  32  to ALU operand A
alu_b  output  32  to ALU operand B
alu_ctrl  output  4  to ALU control
alu_result  input  32  from ALU result
alu_zero  input  1  from ALU zero flag

Behaviour:
- Reset values: state IDLE; req_ready=0; rsp_valid=0; rsp_data=0; rsp_zero=0; rsp_err=0; alu_a=0; alu_b=0; alu_ctrl=0; last_grant=1, so req0 wins the first tie.
- Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0101 SRL, 0100 SLL, 0111 SRA. Every other code is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE, no request: if req_valid==0, stay in IDLE.
- IDLE, grant: otherwise grant g.
  - Only one valid: g is that requester.
  - Both valid: g = ~last_grant.
  - req_ready[g]=1 combinationally in IDLE only; the handshake completes in the same cycle.
- IDLE, legal op accepted: register alu_a, alu_b, alu_ctrl from requester g, clear cnt, go to EXEC.
- IDLE, illegal op accepted: do not touch the alu_* regs. Load rsp_data=0, rsp_zero=0, rsp_err=1, go to RESP.
- EXEC:
  - alu_* held constant; cnt increments each cycle.
  - When cnt==ALU_LAT-1: capture rsp_data=alu_result, rsp_zero=alu_zero, rsp_err=0, go to RESP.
  - EXEC lasts exactly ALU_LAT cycles.
- RESP:
  - rsp_valid[g]=1, and only that bit.
  - rsp_data, rsp_zero and rsp_err stay stable until rsp_ready[g] is high.
  - On the rsp_valid[g]&rsp_ready[g] edge: last_grant<=g, rsp_valid<=0, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
- Latency: accept edge to rsp_valid high = ALU_LAT+1 edges (legal op) or 1 edge (illegal op).
  - Minimum issue interval = ALU_LAT+2 cycles per op.
- req_valid dropped before grant: no effect, no state change.
- A requester whose request is pending must hold its operands until req_ready is seen.
- alu_* outputs keep their last values outside EXEC; no glitching on IDLE.
- Reset mid-EXEC or mid-RESP: the operation is aborted, no response is delivered, all outputs return to reset values on the next edge.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN
- Defined: fixed priority; req0 always wins when both are valid. last_grant is not used for arbitration.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Single request: reset, then req0 ADD A=5 B=7, ALU_LAT=1 -> req_ready[0] high the same cycle; rsp_valid[0] 2 edges later; rsp_data=12, rsp_zero=0, rsp_err=0.
- Zero flag: req1 SUB A=0x10 B=0x10 -> rsp_valid[1], rsp_data=0, rsp_zero=1; rsp_valid[0] stays 0 throughout.
- Contention: both valid continuously with ops (req0 AND 0xF0&0x3C, req1 OR 0xF0|0x0F) -> grants alternate req0, req1, req0; responses 0x30, 0xFF, 0x30. With ALU_ARB_FIXED_PRIO_EN, only req0 is served.
- Illegal op: req0 op=1000 -> rsp_valid[0] 1 edge after accept, rsp_err=1, rsp_data=0, alu_ctrl unchanged.
- Backpressure and latency: ALU_LAT=3, rsp_ready[0] held low 4 cycles -> alu_a, alu_b, alu_ctrl stable for 3 EXEC cycles; rsp_data stable and req_ready=0 for both requesters until rsp_ready rises.
- Reset mid-op: assert rst during EXEC -> next edge state IDLE, all outputs 0, no rsp_valid; the next tie is granted to req0.
